// File: rtl/avmm_key_debounce_pio.sv
`default_nettype none
// ============================================================================
// Module   : avmm_key_debounce_pio
// Brief    : Avalon-MM key/switch input port with per-bit synchroniser,
//            debouncer, sticky edge capture and maskable level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module avmm_key_debounce_pio #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int               c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [WIDTH-1:0] c_idle     = {WIDTH{IDLE_LEVEL}};

    localparam logic [1:0] c_addr_data = 2'd0;
    localparam logic [1:0] c_addr_mask = 2'd1;
    localparam logic [1:0] c_addr_sync = 2'd2;
    localparam logic [1:0] c_addr_edge = 2'd3;

    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        DEBOUNCE_CYCLES < 1 || EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_param
        $error("avmm_key_debounce_pio: parameter out of range");
    end

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] r_deb_d;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] w_clr;
    logic             w_mask_wr;
    logic [31:0]      w_rd_word;
    logic             w_unused;

    // Read strobe is not needed: readdata tracks address every cycle.
    assign w_unused = &{1'b0, read, writedata};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= c_idle;
            end
        end else begin
            r_sync[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_deb;

        // New level accepted only after DEBOUNCE_CYCLES consecutive mismatches.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
                r_deb <= IDLE_LEVEL;
            end else if (w_sync[i] == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_deb <= w_sync[i];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end

        assign w_deb[i] = r_deb;
    end

    if (EDGE_TYPE == 0) begin : g_edge_rise
        assign w_edge = w_deb & ~r_deb_d;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
        assign w_edge = ~w_deb & r_deb_d;
    end else begin : g_edge_any
        assign w_edge = w_deb ^ r_deb_d;
    end

    assign w_clr     = (write && address == c_addr_edge) ? writedata[WIDTH-1:0] : '0;
    assign w_mask_wr = write && (address == c_addr_mask);

    always_comb begin
        w_rd_word = '0;
        case (address)
            c_addr_data: w_rd_word[WIDTH-1:0] = w_deb;
            c_addr_mask: w_rd_word[WIDTH-1:0] = r_irq_mask;
            c_addr_sync: w_rd_word[WIDTH-1:0] = w_sync;
            default:     w_rd_word[WIDTH-1:0] = r_edge_capture;
        endcase
    end

    // A new edge overrides a same-cycle write-1-to-clear on that bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb_d        <= c_idle;
            r_edge_capture <= '0;
            r_irq_mask     <= '0;
            irq            <= 1'b0;
            readdata       <= '0;
        end else begin
            r_deb_d        <= w_deb;
            r_edge_capture <= (r_edge_capture & ~w_clr) | w_edge;
            if (w_mask_wr) begin
                r_irq_mask <= writedata[WIDTH-1:0];
            end
            irq            <= |(r_edge_capture & r_irq_mask);
            readdata       <= w_rd_word;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_avmm_key_debounce_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_avmm_key_debounce_pio
// Brief    : Self-checking bench: directed literal checks plus randomized
//            stimulus compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avmm_key_debounce_pio;

    localparam int W    = 4;
    localparam int SYNC = 2;
    localparam int DC   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    avmm_key_debounce_pio #(
        .WIDTH          (W),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DC),
        .EDGE_TYPE      (1),
        .IDLE_LEVEL     (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .read     (read),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .in_port  (in_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: pins seen SYNC edges late; a bit flips once its last
    // DC synchronised samples all disagree with the current debounced level.
    logic [W-1:0] m_pin_q [$];
    logic [W-1:0] m_win_q [$];
    logic [W-1:0] m_deb, m_deb_old, m_cap, m_mask;
    logic [31:0]  m_rd;
    logic         m_irq;
    bit           m_valid = 1'b0;

    always @(posedge clk) begin : p_model
        logic [W-1:0] sync_pre;
        logic [W-1:0] deb_new;
        logic [W-1:0] fall;
        logic [W-1:0] clr;
        bit           all_diff;
        if (reset) begin
            m_pin_q = {};
            m_win_q = {};
            for (int k = 0; k < SYNC; k++) m_pin_q.push_back({W{1'b1}});
            for (int k = 0; k < DC; k++)   m_win_q.push_back({W{1'b1}});
            m_deb     = {W{1'b1}};
            m_deb_old = {W{1'b1}};
            m_cap     = '0;
            m_mask    = '0;
            m_rd      = '0;
            m_irq     = 1'b0;
        end else begin
            sync_pre = m_pin_q[0];
            m_pin_q.push_back(in_port);
            void'(m_pin_q.pop_front());
            m_win_q.push_back(sync_pre);
            void'(m_win_q.pop_front());
            deb_new = m_deb;
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                foreach (m_win_q[k]) if (m_win_q[k][i] == m_deb[i]) all_diff = 1'b0;
                if (all_diff) deb_new[i] = ~m_deb[i];
            end
            fall = m_deb_old & ~m_deb;
            clr  = (write && address == 2'd3) ? writedata[W-1:0] : '0;
            m_rd = '0;
            case (address)
                2'd0:    m_rd[W-1:0] = m_deb;
                2'd1:    m_rd[W-1:0] = m_mask;
                2'd2:    m_rd[W-1:0] = sync_pre;
                default: m_rd[W-1:0] = m_cap;
            endcase
            m_irq = |(m_cap & m_mask);
            m_cap = (m_cap & ~clr) | fall;
            if (write && address == 2'd1) m_mask = writedata[W-1:0];
            m_deb_old = m_deb;
            m_deb     = deb_new;
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_readdata", readdata, m_rd);
            check("model_irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    initial begin
        int hold;
        reset = 1'b1; in_port = 4'hF; address = 2'd0;
        read = 1'b0; write = 1'b0; writedata = '0;
        repeat (3) tick();
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);

        reset = 1'b0;
        address = 2'd0; read = 1'b1; tick();
        check("idle_data", readdata, 32'h0000000F);
        address = 2'd1; tick();
        check("idle_mask", readdata, 32'h0);
        address = 2'd3; tick();
        check("idle_edge", readdata, 32'h0);
        check("idle_irq", {31'd0, irq}, 32'h0);

        // Three-cycle glitch on bit 0 must be rejected.
        address = 2'd0; in_port = 4'hE;
        repeat (3) tick();
        in_port = 4'hF;
        repeat (8) begin
            tick();
            check("glitch_data", readdata, 32'h0000000F);
        end
        address = 2'd3; tick();
        check("glitch_edge", readdata, 32'h0);

        // Sustained low on bit 0.
        address = 2'd0; in_port = 4'hE;
        repeat (5) tick();
        check("press_data_early", readdata, 32'h0000000F);
        repeat (2) tick();
        check("press_data", readdata, 32'h0000000E);
        address = 2'd3; tick();
        check("press_edge", readdata, 32'h00000001);
        check("press_irq_masked", {31'd0, irq}, 32'h0);

        address = 2'd1; write = 1'b1; writedata = 32'h1; tick();
        write = 1'b0;
        check("mask_irq_lat", {31'd0, irq}, 32'h0);
        tick();
        check("mask_irq", {31'd0, irq}, 32'h1);
        address = 2'd3; write = 1'b1; writedata = 32'h1; tick();
        write = 1'b0;
        check("clr_irq_lat", {31'd0, irq}, 32'h1);
        tick();
        check("clr_irq", {31'd0, irq}, 32'h0);
        check("clr_edge", readdata, 32'h0);

        // Falling edge on bit 2 coincides with its clear.
        in_port = 4'hA;
        repeat (6) tick();
        address = 2'd3; write = 1'b1; writedata = 32'h4; tick();
        write = 1'b0; tick();
        check("set_wins_edge", readdata, 32'h00000004);
        check("set_wins_irq", {31'd0, irq}, 32'h0);

        // Build edge_capture=0x3, then reset with bit 1 mid-count.
        write = 1'b1; writedata = 32'hF; tick();
        write = 1'b0; in_port = 4'hF;
        repeat (10) tick();
        in_port = 4'hC;
        repeat (9) tick();
        check("pre_reset_edge", readdata, 32'h00000003);
        check("pre_reset_irq", {31'd0, irq}, 32'h1);
        in_port = 4'hE;
        repeat (4) tick();
        reset = 1'b1; tick();
        check("midreset_readdata", readdata, 32'h0);
        check("midreset_irq", {31'd0, irq}, 32'h0);
        tick();
        reset = 1'b0; in_port = 4'hF;
        address = 2'd3; tick();
        check("post_reset_edge", readdata, 32'h0);
        address = 2'd0; tick();
        check("post_reset_data", readdata, 32'h0000000F);
        address = 2'd1; tick();
        check("post_reset_mask", readdata, 32'h0);
        address = 2'd3;
        repeat (10) tick();
        check("post_reset_edge_late", readdata, 32'h0);
        check("post_reset_irq", {31'd0, irq}, 32'h0);

        // Randomized phase, checked by the model every cycle.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 1) == 0) in_port = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 9);
            repeat (hold) begin
                address   = 2'($urandom_range(0, 3));
                write     = ($urandom_range(0, 3) == 0);
                read      = ~write;
                writedata = $urandom;
                reset     = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        reset = 1'b0; write = 1'b0; read = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
